// File: rtl/bat_control_pkg.sv
// rtl/bat_control_pkg.sv - shared opcodes, control-bit indices, step constants and state encoding
package bat_control_pkg;

    localparam int BUS_W    = 16;
    localparam int OPCODE_W = 4;
    localparam int STEP_W   = 3;
    localparam int CW_WIDTH = 16;

    typedef logic [OPCODE_W-1:0] opcode_t;

    localparam opcode_t OP_NOP = 4'h0;
    localparam opcode_t OP_LDA = 4'h1;
    localparam opcode_t OP_ADD = 4'h2;
    localparam opcode_t OP_SUB = 4'h3;
    localparam opcode_t OP_STA = 4'h4;
    localparam opcode_t OP_LDI = 4'h5;
    localparam opcode_t OP_JMP = 4'h6;
    localparam opcode_t OP_JC  = 4'h7;
    localparam opcode_t OP_JZ  = 4'h8;
    localparam opcode_t OP_OUT = 4'hE;
    localparam opcode_t OP_HLT = 4'hF;

    localparam int CB_HALT       = 0;
    localparam int CB_MAR_LOAD   = 1;
    localparam int CB_RAM_LOAD   = 2;
    localparam int CB_RAM_ENABLE = 3;
    localparam int CB_IR_LOAD    = 4;
    localparam int CB_IR_ENABLE  = 5;
    localparam int CB_A_LOAD     = 6;
    localparam int CB_A_ENABLE   = 7;
    localparam int CB_ALU_ENABLE = 8;
    localparam int CB_ALU_SUB    = 9;
    localparam int CB_B_LOAD     = 10;
    localparam int CB_OUT_LOAD   = 11;
    localparam int CB_PC_COUNT   = 12;
    localparam int CB_PC_ENABLE  = 13;
    localparam int CB_PC_LOAD    = 14;
    localparam int CB_FLAGS_LOAD = 15;

    localparam int STEP_FETCH_ADDR  = 0;
    localparam int STEP_FETCH_INSTR = 1;
    localparam int STEP_EXEC_FIRST  = 2;
    localparam int STEP_LAST        = 4;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_HALTED  = 2'd2
    } seq_state_t;

    function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
        logic [CW_WIDTH-1:0] w;
        w      = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer bus; STEP_REQ exists only when SINGLE_STEP_EN is defined
interface control_sequencer_if #(
    parameter int BUS_WIDTH  = 16,
    parameter int STEP_WIDTH = 3
);
    logic                  RUN;
    logic [BUS_WIDTH-1:0]  INSTRUCTION_IN;
    logic                  CARRY_FLAG;
    logic                  ZERO_FLAG;
    logic [15:0]           CONTROL_WORD;
    logic [STEP_WIDTH-1:0] STEP_OUT;
    logic                  HALTED;
`ifdef SINGLE_STEP_EN
    logic                  STEP_REQ;
`endif

    modport master (
`ifdef SINGLE_STEP_EN
        output STEP_REQ,
`endif
        output RUN,
        output INSTRUCTION_IN,
        output CARRY_FLAG,
        output ZERO_FLAG,
        input  CONTROL_WORD,
        input  STEP_OUT,
        input  HALTED
    );

    modport slave (
`ifdef SINGLE_STEP_EN
        input  STEP_REQ,
`endif
        input  RUN,
        input  INSTRUCTION_IN,
        input  CARRY_FLAG,
        input  ZERO_FLAG,
        output CONTROL_WORD,
        output STEP_OUT,
        output HALTED
    );
endinterface

// File: rtl/microcode_rom.sv
// rtl/microcode_rom.sv - combinational microcode: control word and last-step flag per opcode/step
module microcode_rom
    import bat_control_pkg::*;
#(
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int STEP_WIDTH   = STEP_W
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [STEP_WIDTH-1:0]   step,
    input  logic                    carry_flag,
    input  logic                    zero_flag,
    output logic [CW_WIDTH-1:0]     control_word,
    output logic                    last_step
);

    always_comb begin
        control_word = '0;
        last_step    = 1'b1;
        if (step == STEP_WIDTH'(STEP_FETCH_ADDR)) begin
            control_word = cw_bit(CB_PC_ENABLE) | cw_bit(CB_MAR_LOAD);
            last_step    = 1'b0;
        end else if (step == STEP_WIDTH'(STEP_FETCH_INSTR)) begin
            control_word = cw_bit(CB_RAM_ENABLE) | cw_bit(CB_IR_LOAD) | cw_bit(CB_PC_COUNT);
            last_step    = 1'b0;
        end else if (step == STEP_WIDTH'(STEP_EXEC_FIRST)) begin
            // Flags only influence the first execute step (conditional jumps)
            case (opcode)
                OP_NOP: control_word = '0;
                OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                    control_word = cw_bit(CB_IR_ENABLE) | cw_bit(CB_MAR_LOAD);
                    last_step    = 1'b0;
                end
                OP_LDI: control_word = cw_bit(CB_IR_ENABLE) | cw_bit(CB_A_LOAD);
                OP_JMP: control_word = cw_bit(CB_IR_ENABLE) | cw_bit(CB_PC_LOAD);
                OP_JC: if (carry_flag) control_word = cw_bit(CB_IR_ENABLE) | cw_bit(CB_PC_LOAD);
                OP_JZ: if (zero_flag)  control_word = cw_bit(CB_IR_ENABLE) | cw_bit(CB_PC_LOAD);
                OP_OUT: control_word = cw_bit(CB_A_ENABLE) | cw_bit(CB_OUT_LOAD);
                OP_HLT: control_word = cw_bit(CB_HALT);
                default: control_word = '0;
            endcase
        end else if (step == STEP_WIDTH'(STEP_EXEC_FIRST + 1)) begin
            case (opcode)
                OP_LDA: control_word = cw_bit(CB_RAM_ENABLE) | cw_bit(CB_A_LOAD);
                OP_ADD, OP_SUB: begin
                    control_word = cw_bit(CB_RAM_ENABLE) | cw_bit(CB_B_LOAD);
                    last_step    = 1'b0;
                end
                OP_STA: control_word = cw_bit(CB_A_ENABLE) | cw_bit(CB_RAM_LOAD);
                default: control_word = '0;
            endcase
        end else if (step == STEP_WIDTH'(STEP_LAST)) begin
            case (opcode)
                OP_ADD: control_word = cw_bit(CB_ALU_ENABLE) | cw_bit(CB_A_LOAD) | cw_bit(CB_FLAGS_LOAD);
                OP_SUB: control_word = cw_bit(CB_ALU_ENABLE) | cw_bit(CB_ALU_SUB) | cw_bit(CB_A_LOAD)
                                     | cw_bit(CB_FLAGS_LOAD);
                default: control_word = '0;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - state/step registers, RUN gating and halt; SINGLE_STEP_EN adds STEP_REQ stepping
module control_sequencer
    import bat_control_pkg::*;
#(
    parameter int BUS_WIDTH    = BUS_W,
    parameter int OPCODE_WIDTH = OPCODE_W,
    parameter int STEP_WIDTH   = STEP_W
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    control_sequencer_if.slave  bus
);

    seq_state_t              state, state_nx;
    logic [STEP_WIDTH-1:0]   step, step_nx, step_inc;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [CW_WIDTH-1:0]     rom_word, cw;
    logic                    rom_last;
    logic                    advance;
    logic                    halted;
    logic [STEP_WIDTH-1:0]   step_out;
    logic                    unused_addr;

    assign opcode      = bus.INSTRUCTION_IN[BUS_WIDTH-1 -: OPCODE_WIDTH];
    assign unused_addr = ^bus.INSTRUCTION_IN[BUS_WIDTH-OPCODE_WIDTH-1:0];
    assign step_inc    = step + STEP_WIDTH'(1);

`ifdef SINGLE_STEP_EN
    // Two-flop synchroniser plus a history flop for rising-edge detection
    logic [2:0] req_sync;
    logic       step_pulse;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) req_sync <= '0;
        else          req_sync <= {req_sync[1:0], bus.STEP_REQ};
    end

    assign step_pulse = req_sync[1] & ~req_sync[2];
    assign advance    = bus.RUN | step_pulse;
`else
    assign advance    = bus.RUN;
`endif

    microcode_rom #(
        .OPCODE_WIDTH (OPCODE_WIDTH),
        .STEP_WIDTH   (STEP_WIDTH)
    ) u_rom (
        .opcode       (opcode),
        .step         (step),
        .carry_flag   (bus.CARRY_FLAG),
        .zero_flag    (bus.ZERO_FLAG),
        .control_word (rom_word),
        .last_step    (rom_last)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_FETCH;
            step  <= '0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        cw       = '0;
        halted   = 1'b0;
        step_out = step;
        case (state)
            ST_FETCH, ST_EXECUTE: begin
                if (advance) begin
                    cw = rom_word;
                    if (step > STEP_WIDTH'(STEP_LAST)) begin
                        state_nx = ST_FETCH;
                        step_nx  = '0;
                    end else if (rom_word[CB_HALT]) begin
                        state_nx = ST_HALTED;
                        step_nx  = '0;
                    end else if (rom_last) begin
                        state_nx = ST_FETCH;
                        step_nx  = '0;
                    end else begin
                        step_nx  = step_inc;
                        state_nx = (step_inc >= STEP_WIDTH'(STEP_EXEC_FIRST)) ? ST_EXECUTE : ST_FETCH;
                    end
                end
            end
            ST_HALTED: begin
                cw       = cw_bit(CB_HALT);
                halted   = 1'b1;
                step_out = '0;
                step_nx  = '0;
            end
            default: begin
                state_nx = ST_FETCH;
                step_nx  = '0;
            end
        endcase
    end

    assign bus.CONTROL_WORD = RESET_N ? cw : '0;
    assign bus.STEP_OUT     = step_out;
    assign bus.HALTED       = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;

    typedef struct {
        logic [15:0] cw;
        logic [2:0]  st;
        logic        h;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_drive = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

    control_sequencer_if bus ();

    control_sequencer dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: queue=%0d", exp_q.size());
        $fatal(1);
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (bus.CONTROL_WORD !== e.cw || bus.STEP_OUT !== e.st || bus.HALTED !== e.h) begin
                n_fail++;
                $display("FAIL %s: got cw=%h step=%0d halted=%b, expected cw=%h step=%0d halted=%b",
                         e.name, bus.CONTROL_WORD, bus.STEP_OUT, bus.HALTED, e.cw, e.st, e.h);
            end
        end
    end

    task automatic cyc(input logic rst, input logic run, input logic [15:0] instr,
                       input logic c, input logic z,
                       input logic [15:0] cw, input logic [2:0] st, input logic h,
                       input string name);
        @(posedge clk);
        #1;
        rst_n              = rst;
        bus.RUN            = run;
        bus.INSTRUCTION_IN = instr;
        bus.CARRY_FLAG     = c;
        bus.ZERO_FLAG      = z;
`ifdef SINGLE_STEP_EN
        bus.STEP_REQ       = req_drive;
`endif
        exp_q.push_back('{cw, st, h, name});
    endtask

    task automatic fetch(input logic [15:0] instr);
        cyc(1, 1, instr, 0, 0, 16'h2002, 3'd0, 0, "fetch0");
        cyc(1, 1, instr, 0, 0, 16'h1018, 3'd1, 0, "fetch1");
    endtask

    initial begin
        bus.RUN            = 1'b0;
        bus.INSTRUCTION_IN = 16'h0000;
        bus.CARRY_FLAG     = 1'b0;
        bus.ZERO_FLAG      = 1'b0;
`ifdef SINGLE_STEP_EN
        bus.STEP_REQ       = 1'b0;
`endif
        cyc(0, 1, 16'h1ABC, 0, 0, 16'h0000, 3'd0, 0, "reset_hold0");
        cyc(0, 1, 16'h1ABC, 0, 0, 16'h0000, 3'd0, 0, "reset_hold1");

        fetch(16'h1ABC);
        cyc(1, 1, 16'h1ABC, 0, 0, 16'h0022, 3'd2, 0, "lda_s2");
        cyc(1, 1, 16'h1ABC, 0, 0, 16'h0048, 3'd3, 0, "lda_s3");

        fetch(16'h2010);
        cyc(1, 1, 16'h2010, 0, 0, 16'h0022, 3'd2, 0, "add_s2");
        cyc(1, 1, 16'h2010, 0, 0, 16'h0408, 3'd3, 0, "add_s3");
        cyc(1, 1, 16'h2010, 0, 0, 16'h8140, 3'd4, 0, "add_s4");

        fetch(16'h3010);
        cyc(1, 1, 16'h3010, 0, 0, 16'h0022, 3'd2, 0, "sub_s2");
        cyc(1, 1, 16'h3010, 0, 0, 16'h0408, 3'd3, 0, "sub_s3");
        cyc(1, 1, 16'h3010, 0, 0, 16'h8340, 3'd4, 0, "sub_s4");

        fetch(16'h7005);
        cyc(1, 1, 16'h7005, 0, 1, 16'h0000, 3'd2, 0, "jc_nocarry");
        fetch(16'h7005);
        cyc(1, 1, 16'h7005, 1, 0, 16'h4020, 3'd2, 0, "jc_carry");
        fetch(16'h8005);
        cyc(1, 1, 16'h8005, 1, 0, 16'h0000, 3'd2, 0, "jz_nozero");
        fetch(16'h8005);
        cyc(1, 1, 16'h8005, 0, 1, 16'h4020, 3'd2, 0, "jz_zero");
        fetch(16'h6123);
        cyc(1, 1, 16'h6123, 0, 0, 16'h4020, 3'd2, 0, "jmp_s2");
        fetch(16'hE000);
        cyc(1, 1, 16'hE000, 0, 0, 16'h0880, 3'd2, 0, "out_s2");
        fetch(16'h4055);
        cyc(1, 1, 16'h4055, 0, 0, 16'h0022, 3'd2, 0, "sta_s2");
        cyc(1, 1, 16'h4055, 0, 0, 16'h0084, 3'd3, 0, "sta_s3");
        fetch(16'h5007);
        cyc(1, 1, 16'h5007, 0, 0, 16'h0060, 3'd2, 0, "ldi_s2");
        fetch(16'hA000);
        cyc(1, 1, 16'hA000, 1, 1, 16'h0000, 3'd2, 0, "op_a_nop");
        fetch(16'h0000);
        cyc(1, 1, 16'h0000, 0, 0, 16'h0000, 3'd2, 0, "nop_s2");

        fetch(16'h1ABC);
        cyc(1, 1, 16'h1ABC, 0, 0, 16'h0022, 3'd2, 0, "lda2_s2");
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 16'h1ABC, 0, 0, 16'h0000, 3'd3, 0, "run_freeze");
        cyc(1, 1, 16'h1ABC, 0, 0, 16'h0048, 3'd3, 0, "run_resume");

        fetch(16'hF000);
        cyc(1, 1, 16'hF000, 0, 0, 16'h0001, 3'd2, 0, "hlt_s2");
        for (int i = 0; i < 10; i++)
            cyc(1, logic'(i % 2), 16'hF000, 0, 0, 16'h0001, 3'd0, 1, "halted_hold");
        cyc(0, 1, 16'hF000, 0, 0, 16'h0000, 3'd0, 0, "halt_reset");
        cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'd0, 0, "post_reset_idle");

`ifdef SINGLE_STEP_EN
        for (int p = 0; p < 3; p++) begin
            logic [15:0] w;
            w = (p == 0) ? 16'h2002 : (p == 1) ? 16'h1018 : 16'h0060;
            req_drive = 1'b1;
            cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'(p), 0, "ss_sync0");
            cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'(p), 0, "ss_sync1");
            cyc(1, 0, 16'h5007, 0, 0, w, 3'(p), 0, "ss_word");
            req_drive = 1'b0;
            cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'((p + 1) % 3), 0, "ss_after0");
            cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'((p + 1) % 3), 0, "ss_after1");
        end
`endif

        cyc(1, 0, 16'h5007, 0, 0, 16'h0000, 3'd0, 0, "idle_run0");
        fetch(16'h5007);
        cyc(1, 1, 16'h5007, 0, 0, 16'h0060, 3'd2, 0, "final_ldi");

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Downstream consumer of the instruction register in the Bat Amateur processor.
- Decodes the 16-bit instruction (opcode [15:12], address [11:0]).
- Runs a microstep counter through fetch and execute, and drives the 16-bit control word that gates every bus load/enable in the datapath.
- Owns the HALT state.

Parameters:
- BUS_WIDTH, 16, instruction width.
- OPCODE_WIDTH, 4, opcode field width at the top of the instruction.
- STEP_WIDTH, 3, microstep counter width (steps 0-4 used).

Ports:
- CLOCK  in  1  system clock, all state changes on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- RUN  in  1  1 = advance one microstep per clock; 0 = freeze.
- INSTRUCTION_IN  in  BUS_WIDTH  instruction from the instruction register.
- CARRY_FLAG  in  1  registered carry from the flags register.
- ZERO_FLAG  in  1  registered zero from the flags register.
- CONTROL_WORD  out  16  one-hot-per-signal control bits (map below).
- STEP_OUT  out  STEP_WIDTH  current microstep.
- HALTED  out  1  high once HLT has executed.

Behaviour:
- Control bit map:
  - 0 HALT, 1 MAR_LOAD, 2 RAM_LOAD, 3 RAM_ENABLE
  - 4 IR_LOAD, 5 IR_ENABLE, 6 A_LOAD, 7 A_ENABLE
  - 8 ALU_ENABLE, 9 ALU_SUB, 10 B_LOAD, 11 OUT_LOAD
  - 12 PC_COUNT, 13 PC_ENABLE, 14 PC_LOAD, 15 FLAGS_LOAD
- States:
  - FETCH (steps 0-1), EXECUTE (steps 2-4), HALTED.
  - Step register and state are registered.
  - CONTROL_WORD is combinational from state, step, opcode and flags; the datapath samples it on the next rising edge.
- Reset (RESET_N low, asynchronous):
  - State FETCH, step 0, HALTED=0.
  - CONTROL_WORD forced 0 while RESET_N is low.
- Fetch microcode:
  - Step 0: PC_ENABLE|MAR_LOAD = 0x2002.
  - Step 1: RAM_ENABLE|IR_LOAD|PC_COUNT = 0x1018.
- Execute microcode by opcode (step 2 onward; the last listed step returns to step 0 / FETCH):
  - 0x0 NOP: step 2 = 0x0000.
  - 0x1 LDA: 2 IR_ENABLE|MAR_LOAD; 3 RAM_ENABLE|A_LOAD.
  - 0x2 ADD: 2 IR_ENABLE|MAR_LOAD; 3 RAM_ENABLE|B_LOAD; 4 ALU_ENABLE|A_LOAD|FLAGS_LOAD.
  - 0x3 SUB: as ADD, with ALU_SUB added at step 4.
  - 0x4 STA: 2 IR_ENABLE|MAR_LOAD; 3 A_ENABLE|RAM_LOAD.
  - 0x5 LDI: 2 IR_ENABLE|A_LOAD.
  - 0x6 JMP: 2 IR_ENABLE|PC_LOAD.
  - 0x7 JC: 2 IR_ENABLE|PC_LOAD if CARRY_FLAG, else 0x0000.
  - 0x8 JZ: same form as JC, on ZERO_FLAG.
  - 0xE OUT: 2 A_ENABLE|OUT_LOAD.
  - 0xF HLT: 2 HALT, then next state HALTED.
  - 0x9-0xD: behave as NOP.
- Flags are sampled combinationally during step 2 only.
- RUN=0: step/state hold, CONTROL_WORD forced 0. Resumes at the same step when RUN returns to 1.
- HALTED state:
  - CONTROL_WORD=0x0001, STEP_OUT=0, HALTED=1.
  - RUN ignored; exit only via RESET_N.
- Reset mid-instruction: abandon immediately; first post-reset cycle is step 0 (0x2002).
- Step counter never exceeds 4. Any illegal step value returns to step 0 / FETCH on the next edge.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- When defined:
  - Adds input STEP_REQ (1 bit, asynchronous pushbutton), synchronised with 2 flops and rising-edge detected.
  - While RUN=0, each detected edge allows exactly one microstep: CONTROL_WORD is active for that single cycle, then forced 0 again.
  - STEP_REQ is ignored when RUN=1 or HALTED.
- When undefined: port absent; RUN=0 simply freezes.

Decomposition:
- Shared package bat_control_pkg holds:
  - opcode localparams (NOP..HLT);
  - control-bit index constants;
  - fetch step constants;
  - state encoding.
- One natural sub-module, microcode_rom:
  - combinational; inputs opcode, step, CARRY_FLAG, ZERO_FLAG;
  - outputs control word and a last_step flag.
- control_sequencer keeps the state/step registers, RUN gating and the halt logic.

Test Plan:
- Reset release, RUN=1, INSTRUCTION_IN=0x1ABC (LDA): words per cycle 0x2002, 0x1018, 0x0022, 0x0048, then 0x2002 with STEP_OUT=0.
- INSTRUCTION_IN=0x2010 (ADD): step 4 word 0x8140. Same with 0x3010 (SUB): step 4 word 0x8340.
- INSTRUCTION_IN=0x7005 (JC):
  - CARRY_FLAG=0 gives step 2 = 0x0000, then fetch.
  - CARRY_FLAG=1 gives step 2 = 0x4020.
- INSTRUCTION_IN=0xF000 (HLT):
  - step 2 = 0x0001; HALTED=1 from the next cycle; word stays 0x0001 for 10 cycles with RUN toggling.
  - Pulse RESET_N low: HALTED=0 immediately; next word 0x2002.
- RUN dropped at step 3 of LDA: word 0x0000 and STEP_OUT=3 held 5 cycles; RUN=1 gives 0x0048 on resume.
- With SINGLE_STEP_EN, RUN=0: three STEP_REQ pulses give exactly three single-cycle non-zero words (0x2002, 0x1018, decode of the loaded instruction).
